div5bcd: RTL and testbench

DIV5BCD -- requirements
Module: div5bcd

---
 rtl/div5bcd.sv | 102 ++++++++++
 tb/tb_div5bcd.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/div5bcd.sv
// div5bcd: divides a two-digit BCD number (10*d+u) by 5 using repeated subtraction.
// Latency: done in the cycle after edge floor(V/5)+2 for valid input, after edge 1 for invalid digits.
// Backpressure: ready is high only in IDLE; start is ignored in SUB or DONE and is never queued.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start, d, u     request and BCD tens/units digits, sampled when start=1 and ready=1
//   ready, done     state decodes: IDLE / one-cycle DONE pulse
//   q, r, err       quotient (0..19), remainder (0..4), invalid-digit flag; held until the next load
module div5bcd (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] d,
  input  logic [3:0] u,
  output logic       ready,
  output logic       done,
  output logic [4:0] q,
  output logic [2:0] r,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [6:0]  acc;
  logic [4:0]  count;
  logic        bad_digit;
  logic [6:0]  bin_val;
  logic        acc_ge5;

  assign bad_digit = (d > 4'd9) || (u > 4'd9);
  // 10*d + u as 8*d + 2*d + u; max 99 fits in 7 bits. With a bad digit the
  // value may wrap, but it is never used on that path.
  assign bin_val   = {d, 3'b000} + {2'b00, d, 1'b0} + {3'b000, u};
  assign acc_ge5   = (acc >= 7'd5);

  assign ready = (state == IDLE);
  assign done  = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = bad_digit ? DONE : SUB;
        end
      end
      SUB: begin
        if (!acc_ge5) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= 7'd0;
      count <= 5'd0;
      q     <= 5'd0;
      r     <= 3'd0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= bin_val;
            count <= 5'd0;
            if (bad_digit) begin
              // Invalid request skips SUB and reports immediately.
              q   <= 5'd0;
              r   <= 3'd0;
              err <= 1'b1;
            end
          end
        end
        SUB: begin
          if (acc_ge5) begin
            acc   <= acc - 7'd5;
            count <= count + 5'd1;
          end else begin
            q   <= count;
            r   <= acc[2:0];
            err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div5bcd.sv
module tb_div5bcd;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] d;
  logic [3:0] u;
  logic       ready;
  logic       done;
  logic [4:0] q;
  logic [2:0] r;
  logic       err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [4:0] q;
    logic [2:0] r;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;

  div5bcd dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .d     (d),
    .u     (u),
    .ready (ready),
    .done  (done),
    .q     (q),
    .r     (r),
    .err   (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expectation,
  // including the exact cycle in which it appears.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("q",        {27'd0, q},   {27'd0, e.q});
        chk("r",        {29'd0, r},   {29'd0, e.r});
        chk("err",      {31'd0, err}, {31'd0, e.err});
        chk("done_cyc", cyc,          e.cyc);
        last_exp = e;
      end
    end
  end

  function automatic exp_t model(input int dd, input int uu, input int c);
    exp_t e;
    int v;
    if (dd > 9 || uu > 9) begin
      e.q = 5'd0; e.r = 3'd0; e.err = 1'b1; e.cyc = c + 1;
    end else begin
      v = 10 * dd + uu;
      e.q = 5'(v / 5); e.r = 3'(v % 5); e.err = 1'b0; e.cyc = c + v / 5 + 2;
    end
    return e;
  endfunction

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  // One request; optionally pulse a second start while the first is in SUB.
  task automatic run_op(input int dd, input int uu, input bit poke);
    wait_ready();
    d = 4'(dd); u = 4'(uu); start = 1'b1;
    sb.push_back(model(dd, uu, cyc));
    @(negedge clk);
    start = 1'b0;
    if (poke) begin
      chk("busy_ready", {31'd0, ready}, 32'd0);
      @(negedge clk);
      d = 4'd9; u = 4'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_empty();
    @(negedge clk);
    // Results are held after the DONE cycle.
    chk("hold_q", {27'd0, q}, {27'd0, last_exp.q});
    chk("hold_r", {29'd0, r}, {29'd0, last_exp.r});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; d = 4'd0; u = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_done",  {31'd0, done},  32'd0);
    chk("rst_q",     {27'd0, q},     32'd0);
    chk("rst_r",     {29'd0, r},     32'd0);
    chk("rst_err",   {31'd0, err},   32'd0);

    // Scenario 1, with an ignored start pulse during SUB
    run_op(3, 5, 1'b1);

    // Scenario 2: multiples of five
    for (int k = 0; k < 10; k++) run_op((5 * k) / 10, (5 * k) % 10, 1'b0);

    // Scenario 3: maximum value and a non-zero remainder
    run_op(9, 9, 1'b0);
    run_op(4, 7, 1'b0);

    // Scenario 4: invalid digits
    run_op(10, 3, 1'b0);
    run_op(0, 12, 1'b0);

    // Scenario 5: reset during SUB after a result with non-zero q/r
    run_op(4, 7, 1'b0);
    wait_ready();
    d = 4'd8; u = 4'd0; start = 1'b1;
    @(negedge clk);            // after edge 1 (acceptance)
    start = 1'b0;
    repeat (3) @(negedge clk); // after edges 2..4
    chk("sub_ready", {31'd0, ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);            // after edge 5
    rst = 1'b0;
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_done",  {31'd0, done},  32'd0);
    chk("abort_q",     {27'd0, q},     32'd0);
    chk("abort_r",     {29'd0, r},     32'd0);
    chk("abort_err",   {31'd0, err},   32'd0);
    run_op(2, 3, 1'b0);

    // Scenario 6: start held high, done every 6 cycles
    wait_ready();
    d = 4'd1; u = 4'd5; start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      e = model(1, 5, cyc);
      e.cyc = e.cyc + 6 * k;
      sb.push_back(e);
    end
    wait_empty();
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("held_idle_ready", {31'd0, ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
